// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port A (CPU) and port B (loader/debug) share one memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port A wins every tie.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;

  state_t            state, state_next;
  port_t             last_winner, cmd_port, winner;
  logic              win;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  always_comb begin
    win        = 1'b0;
    winner     = PORT_A;
    state_next = state;
    case (state)
      IDLE, RESP: begin
        state_next = IDLE;
        if (a_req && b_req) begin
          win    = 1'b1;
          // last_winner is tracked in both builds; only round-robin consults it
          winner = (RR_EN && last_winner == PORT_A) ? PORT_B : PORT_A;
        end else if (a_req) begin
          win    = 1'b1;
          winner = PORT_A;
        end else if (b_req) begin
          win    = 1'b1;
          winner = PORT_B;
        end
        if (win) state_next = ACCESS;
      end
      ACCESS:  state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_winner <= PORT_B;
      cmd_port    <= PORT_A;
      cmd_we      <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
    end else begin
      state <= state_next;
      if (win) begin
        last_winner <= winner;
        cmd_port    <= winner;
        cmd_we      <= (winner == PORT_A) ? a_we    : b_we;
        cmd_addr    <= (winner == PORT_A) ? a_addr  : b_addr;
        cmd_wdata   <= (winner == PORT_A) ? a_wdata : b_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (state == ACCESS && !cmd_we) begin
      if (cmd_port == PORT_A) a_rdata <= mem_read_data;
      else                    b_rdata <= mem_read_data;
    end
  end

  always_comb begin
    busy           = (state == ACCESS);
    mem_address    = cmd_addr;
    mem_write_data = cmd_wdata;
    mem_write      = busy && cmd_we;
    mem_read       = busy && !cmd_we;
    a_gnt          = busy && (cmd_port == PORT_A);
    b_gnt          = busy && (cmd_port == PORT_B);
    a_rvalid       = (state == RESP) && !cmd_we && (cmd_port == PORT_A);
    b_rvalid       = (state == RESP) && !cmd_we && (cmd_port == PORT_B);
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single data_memory port between the CPU datapath (port A) and a loader/debug master (port B). Each winning request becomes one memory access issued from registered command state. Reads return through a one-cycle response pulse. Sits between cpu_top's load/store path, the loader, and data_memory.

Parameters:
ADDR_W, 8, address width of data_memory
DATA_W, 8, data width of data_memory

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (low = reset asserted)
a_req  input  1  port A request; held high until a_gnt is seen
a_we  input  1  port A: 1 = store, 0 = load; stable while a_req is high
a_addr  input  ADDR_W  port A address
a_wdata  input  DATA_W  port A store data
a_gnt  output  1  one-cycle pulse: port A access is on the memory this cycle
a_rvalid  output  1  one-cycle pulse: a_rdata is valid (loads only)
a_rdata  output  DATA_W  port A load data
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A, for port B
mem_address  output  ADDR_W  to data_memory.address
mem_write_data  output  DATA_W  to data_memory.write_data
mem_write  output  1  to data_memory.mem_write
mem_read  output  1  to data_memory.mem_read
mem_read_data  input  DATA_W  from data_memory.read_data; valid in the same cycle as mem_read
busy  output  1  high in ACCESS state

Behaviour:
- State machine states: IDLE, ACCESS, RESP. Register last_winner records the port that won the most recent arbitration.
- Reset (rst low, asynchronous):
  - state = IDLE; last_winner = B.
  - All gnt, rvalid, mem_write, mem_read and busy = 0.
  - a_rdata, b_rdata, mem_address and mem_write_data = 0.
  - An in-flight access is discarded: no gnt or rvalid is emitted after reset releases.
- IDLE or RESP: sample a_req and b_req.
  - Neither high: go to (or stay in) IDLE.
  - Exactly one high: that port wins.
  - Both high: the port not equal to last_winner wins (round-robin).
  - On a win: latch the winner's we, addr, wdata and port id; update last_winner; go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_address and mem_write_data come from the latched command.
  - mem_write = latched we; mem_read = !latched we.
  - The winner's gnt = 1; busy = 1.
  - For a load, capture mem_read_data into the winner's rdata at the end of the cycle.
  - Next state is RESP.
- RESP (one cycle):
  - Load: the winner's rvalid = 1. For a store, no rvalid.
  - Arbitration runs in the same cycle, with the same rules as IDLE.
- Latency: request first seen in cycle N gives gnt in N+1 and rvalid in N+2. Sustained throughput is one access every 2 cycles.
- Requester rule: drop req on the clock edge that ends the gnt cycle. A req still high in the following cycle counts as a new request.
- Outside ACCESS: mem_write = mem_read = 0; mem_address and mem_write_data hold their last values.
- rdata holds its value until the next load on that port.
- mem_write and mem_read are never asserted together. gnt never goes to both ports in the same cycle.
- Request arriving during ACCESS: it is not sampled until RESP.
- Address wrap: none. The address passes through unmodified over the full range 0 to 2^ADDR_W-1.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: ties go to the port not equal to last_winner, as described above.
- Not defined: fixed priority, port A always wins ties. last_winner is still maintained but ignored, and port B can be starved under continuous port A requests.

Test Plan:
1. Single A store: a_req=1, a_we=1, a_addr=8'h10, a_wdata=8'h5A at cycle 0 -> a_gnt=1 and mem_write=1 with mem_address=8'h10, mem_write_data=8'h5A at cycle 1; no a_rvalid; state IDLE by cycle 3.
2. Single B load of preloaded Mem[8'h10]=8'h5A: b_req=1, b_we=0 at cycle 0 -> mem_read=1 and b_gnt=1 at cycle 1; b_rvalid=1 with b_rdata=8'h5A at cycle 2.
3. Simultaneous loads after reset, A addr 8'h01 (=8'h11), B addr 8'h02 (=8'h22), both held -> A granted at cycle 1 and rvalid 8'h11 at cycle 2. B granted at cycle 3 and rvalid 8'h22 at cycle 4 (round-robin). With the macro undefined and A re-requesting each time, A is granted at cycles 1, 3 and 5.
4. Continuous requests from both ports for 8 accesses -> grants alternate A,B,A,B (macro defined); mem_write and mem_read are never both 1; never two gnts in one cycle.
5. Reset mid-access: assert rst low during ACCESS of an A store to 8'h20 -> all outputs 0 immediately (asynchronous). After release there is no a_gnt or a_rvalid, and arbitration restarts with A winning the first tie.
6. Boundary address: a B store of 8'hFF to address 8'hFF, then a B load of 8'hFF -> b_rdata=8'hFF; mem_address=8'hFF with no wrap.
